dram_lut_rd_sequencer: RTL and testbench

Sequences burst reads from the DRAM lookup table into the downstream playback FIFO. It walks a programmed address window, either once or looping, and issues read commands over a valid/ack handshake. It bounds the number of in-flight reads and back-pressures on FIFO almost-full. It also packs a status word that the software-visible rd_valid register samples through its user_data_in input.

---
 rtl/dram_lut_pkg.sv | 20 ++
 rtl/dram_lut_outstanding_ctr.sv | 40 ++++
 rtl/dram_lut_rd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_dram_lut_rd_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_lut_pkg.sv
// Shared types and constants for the DRAM LUT read sequencer.
// State encoding, status-word bit positions and default widths.
package dram_lut_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int CNT_W_DEF   = 24;
  localparam int MAX_OUT_DEF = 8;

  localparam int BUSY_BIT = 31;
  localparam int ERR_BIT  = 30;
  localparam int OUT_LSB  = 24;
  localparam int WRAP_MSB = 23;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/dram_lut_outstanding_ctr.sv
// In-flight read burst counter with sticky underflow error.
// Ports: clk/rst, inc (accept), dec (return), clr_err, count, full, err.
module dram_lut_outstanding_ctr
  import dram_lut_pkg::*;
#(
  parameter  int MAX_OUT = MAX_OUT_DEF,
  localparam int CW      = $clog2(MAX_OUT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr_err,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err
);

  assign full = (count == CW'(MAX_OUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      // An accept and a return in the same cycle cancel out.
      if (inc && !dec)
        count <= count + 1'b1;
      else if (!inc && dec && count != '0)
        count <= count - 1'b1;
      // A return with nothing in flight is flagged; a new
      // underflow takes precedence over a clear in the same cycle.
      if (dec && !inc && count == '0)
        err <= 1'b1;
      else if (clr_err)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_lut_rd_sequencer.sv
// Walks a DRAM LUT address window issuing burst reads to a playback FIFO.
// Ports: start/stop/loop_en/base_addr/num_bursts control, fifo_afull,
// cmd_valid/cmd_addr/cmd_ack command handshake, rd_dvalid returns,
// busy/done status and the packed rd_valid_status word.
module dram_lut_rd_sequencer
  import dram_lut_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int STRIDE  = 1
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_bursts,
  input  logic              fifo_afull,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ack,
  input  logic              rd_dvalid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rd_valid_status
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  state_t            state, state_n;
  logic              cmd_valid_n;
  logic [ADDR_W-1:0] addr_n, base_r, base_n;
  logic [CNT_W-1:0]  num_r, num_n;
  logic [CNT_W-1:0]  issued, issued_n;
  logic [CNT_W-1:0]  wrap, wrap_n;
  logic              loop_r, loop_n;
  logic              stop_pend, stop_n;
  logic              done_n;
  logic              clr_err;
  logic              accept;
  logic              stop_seen;
  logic [CW-1:0]     out_cnt;
  logic              full;
  logic              err;
  logic [31:0]       status_n;

  assign accept    = cmd_valid && cmd_ack;
  assign stop_seen = stop_pend || stop;
  assign busy      = (state != IDLE);

  dram_lut_outstanding_ctr #(
    .MAX_OUT (MAX_OUT)
  ) u_ctr (
    .clk     (user_clk),
    .rst     (user_rst),
    .inc     (accept),
    .dec     (rd_dvalid),
    .clr_err (clr_err),
    .count   (out_cnt),
    .full    (full),
    .err     (err)
  );

  always_comb begin
    state_n     = state;
    cmd_valid_n = cmd_valid;
    addr_n      = cmd_addr;
    base_n      = base_r;
    num_n       = num_r;
    loop_n      = loop_r;
    issued_n    = issued;
    wrap_n      = wrap;
    stop_n      = stop_pend;
    done_n      = 1'b0;
    clr_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr_err = 1'b1;
          if (num_bursts != '0) begin
            base_n      = base_addr;
            num_n       = num_bursts;
            loop_n      = loop_en;
            addr_n      = base_addr;
            issued_n    = '0;
            wrap_n      = '0;
            stop_n      = 1'b0;
            state_n     = ISSUE;
            // Raise straight away so the first command follows start.
            cmd_valid_n = !fifo_afull && !full;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (stop)
          stop_n = 1'b1;
        if (accept) begin
          cmd_valid_n = 1'b0;
          addr_n      = cmd_addr + ADDR_W'(STRIDE);
          if (issued == num_r - 1'b1) begin
            issued_n = '0;
            if (loop_r) begin
              addr_n = base_r;
              if (wrap != '1)
                wrap_n = wrap + 1'b1;
            end else begin
              state_n = DRAIN;
            end
          end else begin
            issued_n = issued + 1'b1;
          end
        end else if (!cmd_valid && !full && !fifo_afull && !stop_seen) begin
          cmd_valid_n = 1'b1;
        end
        // A raised command is never withdrawn; stop waits for its ack.
        if (stop_seen && (!cmd_valid || accept))
          state_n = DRAIN;
      end
      DRAIN: begin
        if (out_cnt == '0 && !rd_dvalid) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    status_n                    = '0;
    status_n[BUSY_BIT]          = (state != IDLE);
    status_n[ERR_BIT]           = err;
    status_n[OUT_LSB +: 6]      = 6'(out_cnt);
    status_n[WRAP_MSB:0]        = 24'(wrap);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state           <= IDLE;
      cmd_valid       <= 1'b0;
      cmd_addr        <= '0;
      base_r          <= '0;
      num_r           <= '0;
      loop_r          <= 1'b0;
      issued          <= '0;
      wrap            <= '0;
      stop_pend       <= 1'b0;
      done            <= 1'b0;
      rd_valid_status <= '0;
    end else begin
      state           <= state_n;
      cmd_valid       <= cmd_valid_n;
      cmd_addr        <= addr_n;
      base_r          <= base_n;
      num_r           <= num_n;
      loop_r          <= loop_n;
      issued          <= issued_n;
      wrap            <= wrap_n;
      stop_pend       <= stop_n;
      done            <= done_n;
      rd_valid_status <= status_n;
    end
  end

endmodule

// File: tb/tb_dram_lut_rd_sequencer.sv
// Self-checking bench for dram_lut_rd_sequencer.
// Expected command addresses are queued at start and popped on each accept.
module tb_dram_lut_rd_sequencer;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [23:0] base_addr = '0;
  logic [23:0] num_bursts = '0;
  logic        fifo_afull = 1'b0;
  logic        cmd_ack = 1'b0;
  logic        man_dv = 1'b0;
  logic        auto_dv = 1'b0;
  logic        rd_dvalid;
  logic        cmd_valid;
  logic [23:0] cmd_addr;
  logic        busy;
  logic        done;
  logic [31:0] rd_valid_status;

  assign rd_dvalid = man_dv | auto_dv;

  dram_lut_rd_sequencer dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
    .base_addr       (base_addr),
    .num_bursts      (num_bursts),
    .fifo_afull      (fifo_afull),
    .cmd_valid       (cmd_valid),
    .cmd_addr        (cmd_addr),
    .cmd_ack         (cmd_ack),
    .rd_dvalid       (rd_dvalid),
    .busy            (busy),
    .done            (done),
    .rd_valid_status (rd_valid_status)
  );

  always #5 user_clk = ~user_clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int ret_mode = 0;
  int ret_lat = 3;
  int held = 0;
  logic [23:0] exp_q[$];
  int due_q[$];

  // Accept monitor / scoreboard and read-return model.
  always @(negedge user_clk) begin
    logic [23:0] e;
    int hit;
    cyc++;
    if (cmd_valid === 1'b1 && cmd_ack === 1'b1) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept_addr: unexpected accept addr=%0h", cmd_addr);
      end else begin
        e = exp_q.pop_front();
        if (cmd_addr !== e) begin
          errors++;
          $display("FAIL accept_addr: got %0h required %0h", cmd_addr, e);
        end
      end
      if (ret_mode == 1) due_q.push_back(cyc + ret_lat);
      else if (ret_mode == 2) held++;
    end
    hit = -1;
    foreach (due_q[i]) if (hit < 0 && due_q[i] <= cyc) hit = i;
    auto_dv = 1'b0;
    if (hit >= 0) begin
      auto_dv = 1'b1;
      due_q.delete(hit);
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] b, input logic [23:0] n,
                          input logic lp);
    base_addr  = b;
    num_bursts = n;
    loop_en    = lp;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    tick();
    checks++;
    if ({cmd_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 000", {cmd_valid, busy, done});
    end
    checks++;
    if (cmd_addr !== 24'h0) begin
      errors++;
      $display("FAIL reset_addr: got %0h required 0", cmd_addr);
    end
    checks++;
    if (rd_valid_status !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: got %h required 0", rd_valid_status);
    end
    user_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    bit seen;
    int dn;
    ret_mode = 1; ret_lat = 3; cmd_ack = 1'b1; acc_cnt = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(24'h100 + 24'(i));
    do_start(24'h100, 24'd4, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: cmd_valid=%b required 1", cmd_valid);
    end
    wait_done(100, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_done: done=0 required 1");
    end
    dn = 0;
    repeat (4) begin
      tick();
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL single_done_once: extra=%0d required 0", dn);
    end
    checks++;
    if (acc_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_accepts: got %0d required 4", acc_cnt);
    end
    checks++;
    if (rd_valid_status[31:24] !== 8'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: status=%h busy=%b required 00/0",
               rd_valid_status[31:24], busy);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_outstanding_cap();
    bit seen;
    int peak;
    bit raised;
    ret_mode = 2; held = 0; acc_cnt = 0; cmd_ack = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(24'h200 + 24'(i));
    do_start(24'h200, 24'd20, 1'b0);
    peak = 0; raised = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (int'(rd_valid_status[29:24]) > peak)
        peak = int'(rd_valid_status[29:24]);
      if (i >= 22 && cmd_valid !== 1'b0) raised = 1'b1;
    end
    checks++;
    if (acc_cnt != 8) begin
      errors++;
      $display("FAIL cap_accepts: got %0d required 8", acc_cnt);
    end
    checks++;
    if (raised) begin
      errors++;
      $display("FAIL cap_hold_low: cmd_valid=1 required 0");
    end
    checks++;
    if (peak != 8) begin
      errors++;
      $display("FAIL cap_peak: got %0d required 8", peak);
    end
    ret_mode = 1; ret_lat = 3;
    for (int i = 0; i < held; i++) due_q.push_back(cyc + 1 + i);
    held = 0;
    wait_done(400, seen);
    checks++;
    if (!seen || acc_cnt != 20 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cap_finish: done=%b accepts=%0d required 1/20",
               seen, acc_cnt);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_loop_wrap();
    bit seen;
    ret_mode = 1; ret_lat = 3; cmd_ack = 1'b1; acc_cnt = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(24'h10 + 24'(i % 3));
    do_start(24'h10, 24'd3, 1'b1);
    for (int i = 0; i < 200 && acc_cnt < 10; i++) tick();
    checks++;
    if (acc_cnt != 10) begin
      errors++;
      $display("FAIL loop_accepts: got %0d required 10", acc_cnt);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(100, seen);
    checks++;
    if (!seen || acc_cnt != 10) begin
      errors++;
      $display("FAIL loop_drain: done=%b accepts=%0d required 1/10",
               seen, acc_cnt);
    end
    tick();
    tick();
    checks++;
    if (rd_valid_status[23:0] !== 24'd3) begin
      errors++;
      $display("FAIL loop_wrap: got %0d required 3", rd_valid_status[23:0]);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    bit seen;
    bit stable;
    bit extra;
    ret_mode = 1; ret_lat = 3; cmd_ack = 1'b0; acc_cnt = 0;
    exp_q.push_back(24'h300);
    do_start(24'h300, 24'd8, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_raise: cmd_valid=%b required 1", cmd_valid);
    end
    fifo_afull = 1'b1;
    stop = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      tick();
      stop = 1'b0;
      if (cmd_valid !== 1'b1 || cmd_addr !== 24'h300) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: cmd_valid=%b addr=%0h required 1/300",
               cmd_valid, cmd_addr);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    seen = 1'b0; extra = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (cmd_valid !== 1'b0) extra = 1'b1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || extra || acc_cnt != 1) begin
      errors++;
      $display("FAIL hold_drain: done=%b extra=%b accepts=%0d required 1/0/1",
               seen, extra, acc_cnt);
    end
    fifo_afull = 1'b0;
  endtask

  task automatic test_spurious_simul();
    bit seen;
    ret_mode = 0; acc_cnt = 0; cmd_ack = 1'b0;
    man_dv = 1'b1;
    tick();
    man_dv = 1'b0;
    tick();
    tick();
    checks++;
    if (rd_valid_status[30] !== 1'b1 || rd_valid_status[29:24] !== 6'd0) begin
      errors++;
      $display("FAIL spurious_err: err=%b out=%0d required 1/0",
               rd_valid_status[30], rd_valid_status[29:24]);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(24'h400 + 24'(i));
    cmd_ack = 1'b1;
    do_start(24'h400, 24'd8, 1'b0);
    for (int i = 0; i < 50 && acc_cnt < 2; i++) tick();
    checks++;
    if (acc_cnt != 2 || rd_valid_status[30] !== 1'b0) begin
      errors++;
      $display("FAIL start_clr_err: accepts=%0d err=%b required 2/0",
               acc_cnt, rd_valid_status[30]);
    end
    tick();
    man_dv = 1'b1;
    tick();
    man_dv = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (rd_valid_status[29:24] !== 6'd2 || acc_cnt != 3) begin
      errors++;
      $display("FAIL simul_events: out=%0d accepts=%0d required 2/3",
               rd_valid_status[29:24], acc_cnt);
    end
    man_dv = 1'b1;
    tick();
    tick();
    man_dv = 1'b0;
    wait_done(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL simul_done: done=0 required 1");
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit active;
    ret_mode = 2; held = 0; acc_cnt = 0; cmd_ack = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(24'h500 + 24'(i));
    do_start(24'h500, 24'd20, 1'b0);
    for (int i = 0; i < 50 && acc_cnt < 5; i++) tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || rd_valid_status[29:24] !== 6'd5) begin
      errors++;
      $display("FAIL midop_setup: cmd_valid=%b out=%0d required 1/5",
               cmd_valid, rd_valid_status[29:24]);
    end
    cmd_ack = 1'b0;
    user_rst = 1'b1;
    tick();
    checks++;
    if ({cmd_valid, busy, done} !== 3'b000 || cmd_addr !== 24'h0 ||
        rd_valid_status !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: ctl=%b addr=%0h status=%h required 0",
               {cmd_valid, busy, done}, cmd_addr, rd_valid_status);
    end
    user_rst = 1'b0;
    ret_mode = 0; held = 0;
    due_q.delete();
    do_start(24'h0, 24'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_start: done=%b cmd_valid=%b required 1/0",
               done, cmd_valid);
    end
    active = 1'b0;
    repeat (10) begin
      tick();
      if (cmd_valid !== 1'b0 || busy !== 1'b0) active = 1'b1;
    end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL zero_quiet: activity=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_outstanding_cap();
    test_loop_wrap();
    test_hold_backpressure();
    test_spurious_simul();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
